// File: rtl/switch_debouncer_pkg.sv
// ============================================================================
// switch_debouncer_pkg : shared state type, sync depth and debounce-cycle helper
// Rev 1.0
// ============================================================================
`default_nettype none

package switch_debouncer_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  function automatic int db_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_debouncer_channel.sv
// ============================================================================
// debounce_channel : one switch bit -> 2-FF synchroniser + stability FSM/counter
// Optional edge pulses when SWITCH_DEBOUNCE_EDGE_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int DB_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic sw_o,
  output logic settling_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sw_q, sw_d;
  logic                   commit;

  // Pure flop chain: nothing may sit between the metastability stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign sw_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sw_s != sw_q) begin
          state_d = ST_SETTLING;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_SETTLING: begin
        if (sw_s == sw_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          sw_d    = sw_s;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw_o       = sw_q;
  assign settling_o = (state_q == ST_SETTLING);

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses land on the same edge as the new debounced level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= commit & sw_s;
      fall_q <= commit & ~sw_s;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
// switch_debouncer : N_CH independent switch debouncers feeding the gate stage
// Edge outputs active only with SWITCH_DEBOUNCE_EDGE_EN defined.  Rev 1.0
// ============================================================================
`default_nettype none

module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int N_CH        = 2
) (
  input  logic            I_P_CLK,
  input  logic            I_P_RST_N,
  input  logic [N_CH-1:0] I_P_SW,
  output logic [N_CH-1:0] O_P_SW,
  output logic [N_CH-1:0] O_P_SETTLING,
  output logic [N_CH-1:0] O_P_RISE,
  output logic [N_CH-1:0] O_P_FALL
);

  localparam int DB_CYCLES = db_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);

  // A one-cycle window could never distinguish a glitch from a change.
  if (DB_CYCLES < 2) begin : g_bad_cfg
    $error("switch_debouncer: DB_CYCLES must be >= 2");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES (DB_CYCLES)
    ) u_ch (
      .clk_i      (I_P_CLK),
      .rst_ni     (I_P_RST_N),
      .sw_i       (I_P_SW[g]),
      .sw_o       (O_P_SW[g]),
      .settling_o (O_P_SETTLING[g]),
      .rise_o     (O_P_RISE[g]),
      .fall_o     (O_P_FALL[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// tb_switch_debouncer : directed bench, CLK_FREQ_HZ=1000, DEBOUNCE_MS=8 (8 cycles)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_switch_debouncer;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw_i;
  logic [1:0] sw_o, settling_o, rise_o, fall_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .CLK_FREQ_HZ (1000),
    .DEBOUNCE_MS (8),
    .N_CH        (2)
  ) dut (
    .I_P_CLK      (clk),
    .I_P_RST_N    (rst_n),
    .I_P_SW       (sw_i),
    .O_P_SW       (sw_o),
    .O_P_SETTLING (settling_o),
    .O_P_RISE     (rise_o),
    .O_P_FALL     (fall_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // Test 1: reset with switches high, then 10-clock release latency
    rst_n = 1'b0;
    sw_i  = 2'b11;
    #2;
    check("rst_sw", 32'(sw_o), 32'h0);
    check("rst_settling", 32'(settling_o), 32'h0);
    check("rst_rise", 32'(rise_o), 32'h0);
    check("rst_fall", 32'(fall_o), 32'h0);
    tick();
    tick();
    check("rst_hold_sw", 32'(sw_o), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("t1_sw", 32'(sw_o), (k >= 10) ? 32'h3 : 32'h0);
      check("t1_settling", 32'(settling_o), (k >= 3 && k <= 9) ? 32'h3 : 32'h0);
      check("t1_rise", 32'(rise_o), (EDGE_EN && k == 10) ? 32'h3 : 32'h0);
    end

    // Test 2: 7-clock pulse on ch0 is rejected
    rst_n = 1'b0;
    sw_i  = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t2_start_sw", 32'(sw_o), 32'h0);
    sw_i = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("t2_sw", 32'(sw_o), 32'h0);
      check("t2_settling", 32'(settling_o), (k >= 3 && k <= 9) ? 32'h1 : 32'h0);
      if (k == 7) sw_i = 2'b00;
    end

    // Test 3: bounce then steady high on ch0, then clean fall
    sw_i = 2'b01; tick();
    sw_i = 2'b00; tick();
    sw_i = 2'b01; tick();
    sw_i = 2'b00; tick();
    check("t3_bounce_sw", 32'(sw_o), 32'h0);
    sw_i = 2'b01;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("t3_sw", 32'(sw_o), (k >= 10) ? 32'h1 : 32'h0);
      check("t3_rise", 32'(rise_o), (EDGE_EN && k == 10) ? 32'h1 : 32'h0);
      check("t3_fall", 32'(fall_o), 32'h0);
    end
    sw_i = 2'b00;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("t3f_sw", 32'(sw_o), (k >= 10) ? 32'h0 : 32'h1);
      check("t3f_fall", 32'(fall_o), (EDGE_EN && k == 10) ? 32'h1 : 32'h0);
      check("t3f_rise", 32'(rise_o), 32'h0);
    end

    // Test 4: both rise together, ch1 glitches low for one clock at clock 4
    sw_i = 2'b11;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("t4_sw", 32'(sw_o), {30'h0, (k >= 14), (k >= 10)});
      if (k == 3) sw_i = 2'b01;
      if (k == 4) sw_i = 2'b11;
    end

    // Test 5: async reset mid-count aborts immediately
    sw_i = 2'b10;
    for (int k = 1; k <= 7; k++) tick();
    check("t5_pre_sw", 32'(sw_o), 32'h3);
    check("t5_pre_settling", 32'(settling_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_sw", 32'(sw_o), 32'h0);
    check("t5_async_settling", 32'(settling_o), 32'h0);
    sw_i = 2'b11;
    tick();
    tick();
    check("t5_hold_sw", 32'(sw_o), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t5_rel_sw", 32'(sw_o), (k >= 10) ? 32'h3 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
